// File: rtl/tree_pipe_pkg.sv
// Shared helpers for the carry-save tree: per-level operand counts and pipeline depth.
package tree_pkg;

    // Operands remaining after lvl rows of 3:2 compression, starting from n.
    function automatic int lvl_count(input int n, input int lvl);
        int c;
        c = n;
        for (int i = 0; i < lvl; i++) c = 2 * (c / 3) + c % 3;
        return c;
    endfunction

    function automatic int csa_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        for (int i = 0; i < 64; i++) begin
            if (c > 2) begin
                c = 2 * (c / 3) + c % 3;
                l++;
            end
        end
        return l;
    endfunction

    function automatic int tree_stages(input int n, input int lps);
        return (csa_levels(n) + lps - 1) / lps;
    endfunction

endpackage

// File: rtl/tree_pipe_csa32.sv
// One row of bitwise 3:2 full adders; carry is returned unshifted.
// Purely combinational, no flow control.
module csa32 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/tree_pipe.sv
// Pipelined Wallace tree + 4:2 carry-save accumulator; latency tree_stages+1 cycles.
// A pending last beat stalls the whole pipe while out_valid is held; in_ready = ~stall.
module tree_pipe
    import tree_pkg::*;
#(
    parameter int NUM_INPUTS       = 8,
    parameter int INPUT_WIDTH      = 64,
    parameter int LEVELS_PER_STAGE = 2,
    parameter int ACC_EN           = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0] in_data,
    input  logic                                   in_last,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INPUT_WIDTH-1:0]                 out_sum0,
    output logic [INPUT_WIDTH-1:0]                 out_sum1
);
    localparam int N   = NUM_INPUTS;
    localparam int W   = INPUT_WIDTH;
    localparam int LPS = LEVELS_PER_STAGE;
    localparam int L   = csa_levels(N);
    localparam int T   = tree_stages(N, LPS);
    localparam int TS  = (T == 0) ? 1 : T;
    localparam int LS  = (L == 0) ? 1 : L;

    typedef logic [W-1:0] word_t;
    typedef struct packed {
        word_t sum0;
        word_t sum1;
    } pair_t;

    word_t        lvl_src   [LS][N];
    word_t        lvl_nx    [L+1][N];
    word_t        tap       [TS][N];
    word_t        stg_dat_q [TS][N];
    word_t        stg_dat_d [TS][N];
    logic [TS-1:0] stg_vld_q, stg_vld_d, stg_last_q, stg_last_d;
    pair_t        acc_q, acc_d, out_q, out_d, fin, res, acc_in;
    logic         out_vld_q, out_vld_d;
    logic         fin_vld, fin_last, stall, in_fire, eff_last;
    word_t        s1, c1, c1_sh, s2, c2;

    for (genvar k = 0; k < N; k++) begin : g_in
        assign lvl_nx[0][k] = in_data[k];
    end

    // Level l reads either the previous level or, at a stage boundary, the stage register.
    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int NC = lvl_count(N, l);
        localparam int G  = NC / 3;
        localparam int R  = NC % 3;
        logic [N-1:0] unused_w;
        for (genvar k = 0; k < N; k++) begin : g_src
            if (l > 0 && (l % LPS) == 0) begin : g_reg
                assign lvl_src[l][k] = stg_dat_q[l/LPS-1][k];
            end else begin : g_cmb
                assign lvl_src[l][k] = lvl_nx[l][k];
            end
            if (k >= NC) begin : g_dead
                assign unused_w[k] = ^lvl_src[l][k];
            end else begin : g_live
                assign unused_w[k] = 1'b0;
            end
        end
        for (genvar g = 0; g < G; g++) begin : g_csa
            word_t carry_w;
            csa32 #(.WIDTH(W)) u_csa (
                .a    (lvl_src[l][3*g]),
                .b    (lvl_src[l][3*g+1]),
                .c    (lvl_src[l][3*g+2]),
                .sum  (lvl_nx[l+1][2*g]),
                .carry(carry_w)
            );
            assign lvl_nx[l+1][2*g+1] = carry_w << 1;
        end
        for (genvar k = 2 * G; k < N; k++) begin : g_pass
            if (k < 2 * G + R) begin : g_fwd
                assign lvl_nx[l+1][k] = lvl_src[l][3*G+k-2*G];
            end else begin : g_zero
                assign lvl_nx[l+1][k] = '0;
            end
        end
    end

    if (T == 0) begin : g_notap
        for (genvar k = 0; k < N; k++) begin : g_z
            assign tap[0][k] = '0;
        end
        assign fin_vld  = in_valid;
        assign fin_last = eff_last;
        assign fin      = {lvl_nx[0][0], lvl_nx[0][1]};
    end else begin : g_tap
        for (genvar s = 0; s < T; s++) begin : g_s
            localparam int LV = ((s + 1) * LPS < L) ? (s + 1) * LPS : L;
            for (genvar k = 0; k < N; k++) begin : g_k
                assign tap[s][k] = lvl_nx[LV][k];
            end
        end
        logic [N-1:0] unused_fin;
        for (genvar k = 0; k < N; k++) begin : g_uf
            if (k >= 2) begin : g_dead
                assign unused_fin[k] = ^stg_dat_q[T-1][k];
            end else begin : g_live
                assign unused_fin[k] = 1'b0;
            end
        end
        assign fin_vld  = stg_vld_q[T-1];
        assign fin_last = stg_last_q[T-1];
        assign fin      = {stg_dat_q[T-1][0], stg_dat_q[T-1][1]};
    end

    // 4:2 compression of the tree pair with the running accumulator pair.
    assign acc_in = (ACC_EN != 0) ? acc_q : '0;
    assign c1_sh  = c1 << 1;
    csa32 #(.WIDTH(W)) u_acc0 (.a(fin.sum0), .b(fin.sum1), .c(acc_in.sum0), .sum(s1), .carry(c1));
    csa32 #(.WIDTH(W)) u_acc1 (.a(s1), .b(c1_sh), .c(acc_in.sum1), .sum(s2), .carry(c2));
    assign res = {s2, c2 << 1};

    assign eff_last = (ACC_EN != 0) ? in_last : 1'b1;
    assign stall    = out_vld_q & ~out_ready & fin_vld & fin_last;
    assign in_ready = ~stall;
    assign in_fire  = in_valid & ~stall;

    always_comb begin
        stg_dat_d  = stg_dat_q;
        stg_vld_d  = stg_vld_q;
        stg_last_d = stg_last_q;
        acc_d      = acc_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        if (!stall) begin
            if (T > 0) begin
                stg_dat_d[0]  = tap[0];
                stg_vld_d[0]  = in_fire;
                stg_last_d[0] = eff_last;
            end
            for (int s = 1; s < T; s++) begin
                stg_dat_d[s]  = tap[s];
                stg_vld_d[s]  = stg_vld_q[s-1];
                stg_last_d[s] = stg_last_q[s-1];
            end
            out_vld_d = out_vld_q & ~out_ready;
            if (fin_vld) begin
                if (fin_last) begin
                    out_d     = res;
                    out_vld_d = 1'b1;
                    acc_d     = '0;
                end else begin
                    acc_d = res;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < TS; s++) begin
                for (int k = 0; k < N; k++) stg_dat_q[s][k] <= '0;
            end
            stg_vld_q  <= '0;
            stg_last_q <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            stg_dat_q  <= stg_dat_d;
            stg_vld_q  <= stg_vld_d;
            stg_last_q <= stg_last_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum0  = out_q.sum0;
    assign out_sum1  = out_q.sum1;

endmodule
